seq_player: RTL and testbench

- Sequence generator and playback stage of the Genius game. It sits directly upstream of Controle and produces its end_FPGA and win inputs.
- On a setup request it fills an internal colour memory from an LFSR.
- When enabled in the PLAY_FPGA phase, it flashes the first `round` colours on four one-hot LEDs, then reports completion.
- It also exposes the stored colours for the downstream user-check logic.

---
 rtl/seq_player.sv | 204 ++++++++++++++++++++
 tb/tb_seq_player.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// seq_player: Genius sequence generator and LED playback stage.
// Fills a colour memory from a Galois LFSR, then flashes the first `round` colours on one-hot LEDs.
module seq_player #(
    parameter int          MAX_ROUND  = 16,
    parameter int          ON_CYCLES  = 25000000,
    parameter int          OFF_CYCLES = 12500000,
    parameter logic [15:0] DEF_SEED   = 16'hACE1
) (
    input  logic                           CLOCK,
    input  logic                           reset,
    input  logic                           R1,
    input  logic                           E1,
    input  logic                           E3,
    input  logic [15:0]                    seed_in,
    input  logic [$clog2(MAX_ROUND)-1:0]   exp_idx,
    output logic [1:0]                     exp_color,
    output logic [3:0]                     leds,
    output logic                           end_FPGA,
    output logic                           win,
    output logic [$clog2(MAX_ROUND+1)-1:0] round,
    output logic                           busy
);
    localparam int IW   = $clog2(MAX_ROUND);
    localparam int RW   = $clog2(MAX_ROUND + 1);
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_CYCLES - 1);
    localparam logic [IW-1:0] GEN_LAST  = IW'(MAX_ROUND - 1);
    localparam logic [IW:0]   MEM_DEPTH = (IW + 1)'(MAX_ROUND);
    localparam logic [RW-1:0] ROUND_MAX = RW'(MAX_ROUND);
    localparam logic [RW-1:0] ROUND_ONE = RW'(1);

    typedef enum logic [2:0] {S_IDLE, S_GEN, S_ON, S_OFF, S_DONE} state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [IW-1:0] gen_idx_reg, gen_idx_next;
    logic [15:0]   lfsr_reg, lfsr_next, lfsr_step;
    logic [3:0]    leds_reg, leds_next;
    logic          end_reg, end_next;
    logic          busy_reg, busy_next;
    logic [RW-1:0] round_reg, round_next;
    logic          e3_reg;

    logic [1:0]    mem [MAX_ROUND];
    logic          mem_we;
    logic [IW-1:0] idx_inc;
    logic [3:0]    led_first, led_following;
    logic          e3_rise, play_last;

    assign idx_inc   = idx_reg + IW'(1);
    assign e3_rise   = E3 & ~e3_reg;
    assign play_last = (RW'(idx_reg) == (round_reg - ROUND_ONE));
    assign lfsr_step = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

    // One-hot decode of the first colour and of the colour that follows the current one.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign led_first[gi]     = (mem[0] == 2'(gi));
            assign led_following[gi] = (mem[idx_inc] == 2'(gi));
        end
    endgenerate

    // Colour memory has no reset: contents are only meaningful after a generation pass.
    always_ff @(posedge CLOCK) begin
        if (mem_we) begin
            mem[gen_idx_reg] <= lfsr_reg[1:0];
        end
    end

    always_comb begin
        exp_color = 2'b00;
        if ({1'b0, exp_idx} < MEM_DEPTH) begin
            exp_color = mem[exp_idx];
        end
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            idx_reg     <= '0;
            gen_idx_reg <= '0;
            lfsr_reg    <= DEF_SEED;
            leds_reg    <= '0;
            end_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            round_reg   <= ROUND_ONE;
            e3_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            idx_reg     <= idx_next;
            gen_idx_reg <= gen_idx_next;
            lfsr_reg    <= lfsr_next;
            leds_reg    <= leds_next;
            end_reg     <= end_next;
            busy_reg    <= busy_next;
            round_reg   <= round_next;
            e3_reg      <= E3;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        idx_next     = idx_reg;
        gen_idx_next = gen_idx_reg;
        lfsr_next    = lfsr_reg;
        leds_next    = leds_reg;
        end_next     = end_reg;
        busy_next    = busy_reg;
        round_next   = round_reg;
        mem_we       = 1'b0;

        if (R1) begin
            state_next   = S_GEN;
            timer_next   = '0;
            gen_idx_next = '0;
            round_next   = ROUND_ONE;
            lfsr_next    = (seed_in == 16'h0000) ? DEF_SEED : seed_in;
            leds_next    = 4'b0000;
            end_next     = 1'b0;
            busy_next    = 1'b1;
        end else begin
            if (e3_rise && (state_reg != S_GEN) && (round_reg != ROUND_MAX)) begin
                round_next = round_reg + ROUND_ONE;
            end
            case (state_reg)
                S_GEN: begin
                    mem_we       = 1'b1;
                    lfsr_next    = lfsr_step;
                    gen_idx_next = gen_idx_reg + IW'(1);
                    if (gen_idx_reg == GEN_LAST) begin
                        state_next = S_IDLE;
                        busy_next  = 1'b0;
                    end
                end
                S_IDLE: begin
                    if (E1 && !busy_reg) begin
                        state_next = S_ON;
                        idx_next   = '0;
                        timer_next = '0;
                        leds_next  = led_first;
                    end
                end
                S_ON: begin
                    if (!E1) begin
                        state_next = S_IDLE;
                        timer_next = '0;
                        leds_next  = 4'b0000;
                    end else if (timer_reg == ON_LAST) begin
                        state_next = S_OFF;
                        timer_next = '0;
                        leds_next  = 4'b0000;
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                S_OFF: begin
                    if (!E1) begin
                        state_next = S_IDLE;
                        timer_next = '0;
                    end else if (timer_reg == OFF_LAST) begin
                        timer_next = '0;
                        if (play_last) begin
                            state_next = S_DONE;
                            end_next   = 1'b1;
                        end else begin
                            state_next = S_ON;
                            idx_next   = idx_inc;
                            leds_next  = led_following;
                        end
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
                S_DONE: begin
                    if (!E1) begin
                        state_next = S_IDLE;
                        end_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    timer_next = '0;
                    leds_next  = 4'b0000;
                    end_next   = 1'b0;
                end
            endcase
        end
    end

    assign leds     = leds_reg;
    assign end_FPGA = end_reg;
    assign busy     = busy_reg;
    assign round    = round_reg;
    assign win      = (round_reg == ROUND_MAX);

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: elapsed-time playback model plus directed literal checks and random stimulus.
module tb_seq_player;
    localparam int MAXR = 4;
    localparam int ONC  = 3;
    localparam int OFFC = 2;
    localparam int PER  = ONC + OFFC;
    localparam int M_IDLE = 0, M_GEN = 1, M_PLAY = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        R1, E1, E3;
    logic [15:0] seed_in;
    logic [1:0]  exp_idx;
    logic [1:0]  exp_color;
    logic [3:0]  leds;
    logic        end_FPGA, win, busy;
    logic [2:0]  round;

    int checks = 0;
    int failures = 0;

    seq_player #(
        .MAX_ROUND (MAXR),
        .ON_CYCLES (ONC),
        .OFF_CYCLES(OFFC),
        .DEF_SEED  (16'hACE1)
    ) dut (
        .CLOCK    (clk),
        .reset    (reset),
        .R1       (R1),
        .E1       (E1),
        .E3       (E3),
        .seed_in  (seed_in),
        .exp_idx  (exp_idx),
        .exp_color(exp_color),
        .leds     (leds),
        .end_FPGA (end_FPGA),
        .win      (win),
        .round    (round),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: playback expressed as elapsed edges since start.
    int          m_mode, m_round, m_gcount, m_elapsed;
    logic [15:0] m_lfsr;
    logic [1:0]  m_mem [MAXR];
    bit          m_valid [MAXR];
    logic [3:0]  m_leds;
    logic        m_end, m_busy, m_e3;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_round = 1; m_gcount = 0; m_elapsed = 0;
        m_lfsr = 16'hACE1; m_leds = 4'b0; m_end = 1'b0; m_busy = 1'b0; m_e3 = 1'b0;
        for (int i = 0; i < MAXR; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_step();
        logic rise;
        int   old_round, k, ph;
        rise = E3 && !m_e3;
        m_e3 = E3;
        old_round = m_round;
        if (R1) begin
            m_mode = M_GEN; m_round = 1; m_gcount = 0;
            m_lfsr = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
            m_leds = 4'b0; m_end = 1'b0; m_busy = 1'b1;
        end else begin
            if (rise && m_mode != M_GEN && m_round < MAXR) m_round++;
            case (m_mode)
                M_GEN: begin
                    m_mem[m_gcount] = m_lfsr[1:0];
                    m_valid[m_gcount] = 1'b1;
                    m_lfsr = galois(m_lfsr);
                    m_gcount++;
                    if (m_gcount == MAXR) begin
                        m_mode = M_IDLE; m_busy = 1'b0;
                    end
                end
                M_IDLE: begin
                    if (E1) begin
                        m_mode = M_PLAY; m_elapsed = 0; m_leds = onehot(m_mem[0]);
                    end
                end
                M_PLAY: begin
                    if (!E1) begin
                        m_mode = M_IDLE; m_leds = 4'b0;
                    end else begin
                        m_elapsed++;
                        k  = m_elapsed / PER;
                        ph = m_elapsed % PER;
                        if (ph == 0 && k == old_round) begin
                            m_mode = M_DONE; m_end = 1'b1; m_leds = 4'b0;
                        end else begin
                            m_leds = (ph < ONC) ? onehot(m_mem[k]) : 4'b0;
                        end
                    end
                end
                default: begin
                    if (!E1) begin
                        m_mode = M_IDLE; m_end = 1'b0;
                    end
                end
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("leds", leds, m_leds);
            check("end_FPGA", end_FPGA, m_end);
            check("round", round, m_round);
            check("busy", busy, m_busy);
            check("win", win, m_round == MAXR);
            if (m_valid[exp_idx]) check("exp_color", exp_color, m_mem[exp_idx]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic regen(input logic [15:0] s);
        seed_in = s; R1 = 1'b1;
        tick();
        R1 = 1'b0;
        repeat (5) tick();
    endtask

    logic [1:0] lit_col [4] = '{2'd1, 2'd0, 2'd0, 2'd0};
    logic [3:0] lit_r2 [10] = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    int         lit_rnd [3] = '{3, 4, 4};
    int         busy_cnt;

    initial begin
        reset = 1'b0; R1 = 1'b0; E1 = 1'b0; E3 = 1'b0; seed_in = 16'h0; exp_idx = 2'd0;
        repeat (2) tick();
        check("rst_leds", leds, 4'h0);
        check("rst_round", round, 1);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // Generation from seed 1
        seed_in = 16'h0001; R1 = 1'b1;
        tick();
        R1 = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        check("busy_cycles", busy_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            exp_idx = 2'(i);
            #1;
            check("gen_color", exp_color, lit_col[i]);
        end

        // Round 1 playback
        E1 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            check("r1_leds", leds, (n <= 3) ? 4'b0010 : 4'b0000);
            check("r1_end", end_FPGA, n == 6);
        end
        tick();
        check("r1_end_hold", end_FPGA, 1);
        E1 = 1'b0;
        tick();
        check("r1_end_clear", end_FPGA, 0);

        // Round 2 playback
        E3 = 1'b1; tick(); E3 = 1'b0; tick();
        check("r2_round", round, 2);
        E1 = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n <= 10) check("r2_leds", leds, lit_r2[n-1]);
            check("r2_end", end_FPGA, n == 11);
        end
        E1 = 1'b0;
        tick();

        // Held E3 counts once, then saturation
        regen(16'h0001);
        E3 = 1'b1;
        repeat (5) tick();
        check("held_round", round, 2);
        E3 = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) begin
            E3 = 1'b1; tick(); E3 = 1'b0; tick();
            check("sat_round", round, lit_rnd[p]);
            check("sat_win", win, p >= 1);
        end

        // Abort during second ON, then R1 with E3
        regen(16'h0001);
        E3 = 1'b1; tick(); E3 = 1'b0; tick();
        E1 = 1'b1;
        repeat (7) tick();
        check("abort_pre_leds", leds, 4'b0001);
        E1 = 1'b0;
        tick();
        check("abort_leds", leds, 4'h0);
        check("abort_round", round, 2);
        tick();
        check("abort_end", end_FPGA, 0);
        R1 = 1'b1; E3 = 1'b1; seed_in = 16'h0001;
        tick();
        R1 = 1'b0; E3 = 1'b0;
        check("r1e3_round", round, 1);
        check("r1e3_busy", busy, 1);
        repeat (5) tick();

        // Reset mid-ON
        E3 = 1'b1; tick(); E3 = 1'b0; tick();
        E1 = 1'b1;
        repeat (2) tick();
        check("pre_rst_leds", leds, 4'b0010);
        reset = 1'b0;
        #1;
        check("async_leds", leds, 4'h0);
        check("async_end", end_FPGA, 0);
        check("async_round", round, 1);
        E1 = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_leds", leds, 4'h0);
        check("post_rst_busy", busy, 0);
        regen(16'($urandom));

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0; R1 = 1'b0; E1 = 1'b0; E3 = 1'b0;
                tick();
                reset = 1'b1; R1 = 1'b1;
                seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                tick();
                R1 = 1'b0;
            end else begin
                R1 = ($urandom_range(0, 79) == 0);
                seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                if ($urandom_range(0, 29) == 0) E1 = ~E1;
                E3 = ($urandom_range(0, 19) == 0) ? 1'b1 : (E3 && ($urandom_range(0, 2) != 0));
                exp_idx = 2'($urandom_range(0, 3));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
